// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share one 8-bit ALU.
//
// A valid/ready handshake on each requester port accepts one operation at a
// time. When both requesters are valid, rr_ptr picks the winner. The winning
// op and operands are latched, and the ALU is driven from those registers for
// EXEC_CYCLES cycles. The result and its Z/N flags are then captured and
// presented on the response channel, tagged with the requester id, until the
// consumer takes them.
//
// Parameters
//   EXEC_CYCLES  ALU settle cycles before capture (1..4)
//   RR_INIT      requester favoured first after reset (0 or 1)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req0_valid/ready/op/a/b    requester 0 (op: 00 ADD, 01 INC, 10 NEG, 11 SUB)
//   req1_valid/ready/op/a/b    requester 1
//   rsp_valid/ready            response handshake
//   rsp_id, rsp_data           issuing requester, ALU result
//   rsp_z, rsp_n               result == 0, result[7]
//   busy                       controller is not idle

// Combinational 8-bit ALU with one-hot operation selects.
module alu (
    input  logic       add,
    input  logic       inc,
    input  logic       neg,
    input  logic       sub,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out,
    output logic       z,
    output logic       n
);
    always_comb begin
        out = 8'h00;
        if (add)
            out = a + b;
        else if (inc)
            out = b + 8'd1;
        else if (neg)
            out = 8'd0 - a;
        else if (sub)
            out = b - a;
    end

    assign z = ~|out;
    assign n = out[7];
endmodule

// state | meaning
// IDLE  | waiting for a request; ready goes to the arbitration winner
// EXEC  | ALU driven from latched op/operands; settle counter running
// RESP  | result held on rsp_* until rsp_ready
module alu_share_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          RR_INIT     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_z,
    output logic       rsp_n,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter runs EXEC_CYCLES-1 .. 0; capture happens on the cycle it reads 0.
    localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       rr_ptr;
    logic [1:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       id_q;
    logic [1:0] cnt;

    logic       any_valid;
    logic       win_id;
    logic       accept;

    logic       alu_add;
    logic       alu_inc;
    logic       alu_neg;
    logic       alu_sub;
    logic [7:0] alu_out;
    logic       alu_z;
    logic       alu_n;

    assign any_valid = req0_valid | req1_valid;
    // A lone requester always wins; rr_ptr only breaks ties.
    assign win_id    = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    assign accept    = (state == IDLE) & any_valid;

    alu u_alu (
        .add (alu_add),
        .inc (alu_inc),
        .neg (alu_neg),
        .sub (alu_sub),
        .a   (a_q),
        .b   (b_q),
        .out (alu_out),
        .z   (alu_z),
        .n   (alu_n)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid)     state_next = EXEC;
            EXEC:    if (cnt == 2'd0)   state_next = RESP;
            RESP:    if (rsp_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_add    = 1'b0;
        alu_inc    = 1'b0;
        alu_neg    = 1'b0;
        alu_sub    = 1'b0;
        busy       = (state != IDLE);
        if (accept) begin
            req0_ready = ~win_id;
            req1_ready = win_id;
        end
        if (state == EXEC) begin
            case (op_q)
                2'b00:   alu_add = 1'b1;
                2'b01:   alu_inc = 1'b1;
                2'b10:   alu_neg = 1'b1;
                default: alu_sub = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= RR_INIT;
            op_q      <= 2'b00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            id_q      <= 1'b0;
            cnt       <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_z     <= 1'b0;
            rsp_n     <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= win_id ? req1_op : req0_op;
                a_q  <= win_id ? req1_a  : req0_a;
                b_q  <= win_id ? req1_b  : req0_b;
                id_q <= win_id;
                cnt  <= CNT_INIT;
            end
            if (state == EXEC) begin
                if (cnt == 2'd0) begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_data  <= alu_out;
                    rsp_z     <= alu_z;
                    rsp_n     <= alu_n;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
            // After a response, favour the other requester next time.
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= ~rsp_id;
            end
        end
    end
endmodule
